contador_ctrl: RTL and testbench
================================

# contador_ctrl

Command-driven controller and checker for the 4-bit mode counter (`contador`). It accepts one command at a time over a valid/ready handshake, then drives the counter's ENB/MODO/D inputs for a programmed number of enabled cycles. It predicts every Q and RCO value with an internal reference model and reports mismatches per command and cumulatively. It sits between a test/sequencing source and the counter, closing the loop on the counter's Q and RCO outputs.

## Interface

**Parameters**
- STEPS_W, 4: width of the step-count field; up to 2^STEPS_W−1 enabled cycles per command.

**Ports**
- CLK  input  1  clock; all state changes on the rising edge.
- RESET_L  input  1  reset, synchronous, active-low.
- CMD_VALID  input  1  a command is present on CMD_MODO/CMD_D/CMD_STEPS.
- CMD_READY  output  1  high only in IDLE; a command is accepted on an edge where CMD_VALID and CMD_READY are both high.
- CMD_MODO  input  2  counter mode: 00 up +1, 01 down −1, 10 down −3, 11 parallel load.
- CMD_D  input  4  load value, used when CMD_MODO=11.
- CMD_STEPS  input  STEPS_W  number of enabled counter cycles.
- ENB  output  1  counter enable.
- MODO  output  2  counter mode.
- D  output  4  counter parallel-load data.
- Q  input  4  counter count output.
- RCO  input  1  counter RCO output.
- DONE  output  1  one-cycle pulse marking command completion.
- ERR  output  1  at least one mismatch occurred in the last or current command.
- ERR_CNT  output  8  total mismatching compare cycles since reset; saturates at 255.
- Q_EXP  output  4  reference-model expected count.

## Operation

**Reference model.** Next count is exp+1, exp−1, exp−3 (all mod 16), or latched D, selected by latched MODO. Expected RCO is 1 for modes 00 and 11, and 0 for modes 01 and 10.

**States**
- **IDLE**
  - Outputs: CMD_READY=1, ENB=0.
  - On accept, latch MODO, D and STEPS into holding registers and clear ERR.
  - Q_EXP ← Q as sampled on the accept edge.
  - Next state: CHECK if CMD_STEPS=0, otherwise RUN.
- **RUN**
  - Outputs: ENB=1, with MODO and D driven from the latched values.
  - Every edge: Q_EXP ← model(Q_EXP) and the step counter decrements.
  - Next state: CHECK when the step counter reaches its final step.
- **CHECK**
  - Outputs: ENB=0, DONE=1.
  - Next state: IDLE unconditionally.

**Compare rule.**
- Compare cycles are every RUN cycle except the first, plus the CHECK cycle.
- A mismatch is Q≠Q_EXP, or RCO≠expected RCO when at least one enabled edge has occurred.
- On each mismatching compare cycle, set ERR and increment ERR_CNT (saturating).
- A CHECK reached with STEPS=0 compares Q only.

**Held outputs.**
- MODO and D keep their latched values in IDLE and CHECK.
- ERR holds until the next accept.
- ERR_CNT clears only on reset.

**Handshake.** CMD_VALID while CMD_READY=0 is ignored and not queued. The source holds command fields stable until accepted.

## Timing

- Accept at edge k.
- RUN occupies cycles k+1 through k+N, with ENB high for exactly N cycles.
- CHECK and DONE occur in cycle k+N+1.
- CMD_READY is high again in cycle k+N+2, so one command takes N+2 cycles.
- STEPS=0: DONE in cycle k+1, no ENB pulse, CMD_READY low for one cycle.
- ERR and Q_EXP are final and valid while DONE=1.
- Reset values: state IDLE, CMD_READY=1 after reset, ENB=0, MODO=00, D=0, DONE=0, ERR=0, ERR_CNT=0, Q_EXP=0.
- Reset mid-command aborts immediately: ENB=0 from the next cycle and no DONE.
- Wrap-around is modulo 16 in every mode:
  - 15 +1 → 0
  - 0 −1 → 15
  - 1 −3 → 14
- ERR_CNT at 255 stays at 255.

## Test plan

1. Counter preloaded to Q=14; command up, STEPS=3 → Q goes 15, 0, 1. ENB high 3 cycles, DONE in cycle k+4, ERR=0, ERR_CNT=0.
2. Q=2; command down-by-3, STEPS=2 → Q_EXP 15 then 12 matches Q. Expected RCO is 0, ERR=0.
3. Command load, D=9, STEPS=1 → Q=9, RCO=1 at CHECK. DONE in cycle k+2, ERR=0.
4. Q=5; command up, STEPS=4, with the bench forcing Q stuck at 5 → mismatches against 6, 7, 8, 9 give ERR=1 and ERR_CNT=4. The next accepted command clears ERR but ERR_CNT stays 4.
5. Command with STEPS=0, CMD_VALID held high → ENB never rises, DONE in cycle k+1, CMD_READY low for exactly one cycle, second accept at k+2.
6. RESET_L low during the second RUN cycle of a STEPS=5 command → ENB=0, no DONE, ERR=0, ERR_CNT=0, CMD_READY=1 after release.

Source files
------------

// File: rtl/contador_ctrl.sv
// contador_ctrl: command-driven sequencer and self-checker for the 4-bit mode counter.
// Accepts one command over valid/ready, drives ENB/MODO/D for the programmed number
// of enabled cycles, and compares the counter's Q/RCO against an internal model.
module contador_ctrl #(
   parameter int unsigned STEPS_W = 4
) (
   input  logic               CLK,
   input  logic               RESET_L,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [1:0]         CMD_MODO,
   input  logic [3:0]         CMD_D,
   input  logic [STEPS_W-1:0] CMD_STEPS,
   output logic               ENB,
   output logic [1:0]         MODO,
   output logic [3:0]         D,
   input  logic [3:0]         Q,
   input  logic               RCO,
   output logic               DONE,
   output logic               ERR,
   output logic [7:0]         ERR_CNT,
   output logic [3:0]         Q_EXP
);

   localparam int unsigned Q_W   = 4;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               ready_q, ready_d;
   logic               enb_q, enb_d;
   logic               done_q, done_d;
   logic [1:0]         modo_q, modo_d;
   logic [Q_W-1:0]     d_q, d_d;
   logic [STEPS_W-1:0] steps_q, steps_d;
   logic               first_q, first_d;
   logic               moved_q, moved_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [Q_W-1:0]     q_exp_q, q_exp_d;

   logic               accept_c;
   logic               exp_rco_c;
   logic               cmp_c;
   logic               rco_chk_c;
   logic               mismatch_c;

   // Reference model of one enabled counter edge
   function automatic logic [Q_W-1:0] model_next(input logic [1:0]     m,
                                                 input logic [Q_W-1:0] e,
                                                 input logic [Q_W-1:0] dv);
      logic [Q_W-1:0] r;
      case (m)
         2'b00:   r = e + Q_W'(1);
         2'b01:   r = e - Q_W'(1);
         2'b10:   r = e - Q_W'(3);
         default: r = dv;
      endcase
      return r;
   endfunction

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b1;
         enb_q     <= 1'b0;
         done_q    <= 1'b0;
         modo_q    <= 2'b00;
         d_q       <= '0;
         steps_q   <= '0;
         first_q   <= 1'b0;
         moved_q   <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         q_exp_q   <= '0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         enb_q     <= enb_d;
         done_q    <= done_d;
         modo_q    <= modo_d;
         d_q       <= d_d;
         steps_q   <= steps_d;
         first_q   <= first_d;
         moved_q   <= moved_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         q_exp_q   <= q_exp_d;
      end
   end

   // Next-state, model update, compare and registered-output decode
   always_comb begin
      state_d   = state_q;
      modo_d    = modo_q;
      d_d       = d_q;
      steps_d   = steps_q;
      first_d   = first_q;
      moved_d   = moved_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      q_exp_d   = q_exp_q;

      accept_c  = CMD_VALID && ready_q;
      exp_rco_c = (modo_q == 2'b00) || (modo_q == 2'b11);
      // First RUN cycle has seen no enabled edge yet, so nothing to compare
      cmp_c      = ((state_q == ST_RUN) && !first_q) || (state_q == ST_CHECK);
      // RCO only meaningful once the counter has been clocked with ENB high
      rco_chk_c  = (state_q == ST_RUN) || moved_q;
      mismatch_c = cmp_c && ((Q != q_exp_q) || (rco_chk_c && (RCO != exp_rco_c)));

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               modo_d  = CMD_MODO;
               d_d     = CMD_D;
               steps_d = CMD_STEPS;
               first_d = 1'b1;
               moved_d = (CMD_STEPS != '0);
               err_d   = 1'b0;
               q_exp_d = Q;
               state_d = (CMD_STEPS == '0) ? ST_CHECK : ST_RUN;
            end
         end
         ST_RUN: begin
            q_exp_d = model_next(modo_q, q_exp_q, d_q);
            first_d = 1'b0;
            steps_d = steps_q - STEPS_W'(1);
            if (steps_q == STEPS_W'(1)) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (mismatch_c) begin
         err_d = 1'b1;
         if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
      end

      ready_d = (state_d == ST_IDLE);
      enb_d   = (state_d == ST_RUN);
      done_d  = (state_d == ST_CHECK);
   end

   assign CMD_READY = ready_q;
   assign ENB       = enb_q;
   assign MODO      = modo_q;
   assign D         = d_q;
   assign DONE      = done_q;
   // Includes the live compare so the verdict is already final while DONE is high
   assign ERR       = err_q | mismatch_c;
   assign ERR_CNT   = err_cnt_q;
   assign Q_EXP     = q_exp_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl: behavioural counter in the loop plus closed-form expectations.
module tb_contador_ctrl;

   localparam int unsigned STEPS_W = 4;

   logic               CLK = 1'b0;
   logic               RESET_L;
   logic               CMD_VALID;
   logic               CMD_READY;
   logic [1:0]         CMD_MODO;
   logic [3:0]         CMD_D;
   logic [STEPS_W-1:0] CMD_STEPS;
   logic               ENB;
   logic [1:0]         MODO;
   logic [3:0]         D;
   logic [3:0]         Q;
   logic               RCO;
   logic               DONE;
   logic               ERR;
   logic [7:0]         ERR_CNT;
   logic [3:0]         Q_EXP;

   int n_assert = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   // Counter stand-in; stuck freezes Q to provoke mismatches
   logic [3:0] cnt     = 4'd0;
   logic       rco_m   = 1'b0;
   logic       stuck   = 1'b0;
   logic       pre_en  = 1'b0;
   logic [3:0] pre_val = 4'd0;

   always #5 CLK = ~CLK;

   contador_ctrl #(.STEPS_W(STEPS_W)) dut (
      .CLK(CLK), .RESET_L(RESET_L), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_MODO(CMD_MODO), .CMD_D(CMD_D), .CMD_STEPS(CMD_STEPS), .ENB(ENB),
      .MODO(MODO), .D(D), .Q(Q), .RCO(RCO), .DONE(DONE), .ERR(ERR),
      .ERR_CNT(ERR_CNT), .Q_EXP(Q_EXP)
   );

   always @(posedge CLK) begin
      if (pre_en) begin
         cnt <= pre_val;
      end else if (ENB) begin
         if (!stuck) begin
            case (MODO)
               2'b00:   cnt <= cnt + 4'd1;
               2'b01:   cnt <= cnt - 4'd1;
               2'b10:   cnt <= cnt - 4'd3;
               default: cnt <= D;
            endcase
         end
         rco_m <= (MODO == 2'b00) || (MODO == 2'b11);
      end
   end

   assign Q   = cnt;
   assign RCO = rco_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected count after i enabled edges, closed form
   function automatic logic [3:0] ref_exp(input logic [1:0] m, input logic [3:0] dv,
                                          input logic [3:0] q0, input int i);
      int v;
      case (m)
         2'b00:   v = int'(q0) + i;
         2'b01:   v = int'(q0) - i;
         2'b10:   v = int'(q0) - 3 * i;
         default: v = (i == 0) ? int'(q0) : int'(dv);
      endcase
      return 4'(v);
   endfunction

   task automatic preload(input logic [3:0] v);
      pre_val = v;
      pre_en  = 1'b1;
      @(negedge CLK);
      pre_en  = 1'b0;
   endtask

   // Issue one command from a negedge in IDLE; returns on the negedge READY is back
   task automatic do_cmd(input logic [1:0] m, input logic [3:0] dv, input int n, input bit stk);
      logic [3:0] q0;
      logic [3:0] e;
      int mism, enb_n, done_c, wait_n;
      bit exp_err;
      stuck     = stk;
      CMD_MODO  = m;
      CMD_D     = dv;
      CMD_STEPS = STEPS_W'(n);
      CMD_VALID = 1'b1;
      wait_n = 0;
      while (CMD_READY !== 1'b1 && wait_n < 40) begin
         @(negedge CLK);
         wait_n++;
      end
      chk("accept_wait", 32'(wait_n), 32'd0);
      q0 = cnt;
      @(posedge CLK);
      mism = 0;
      for (int i = 1; i <= n; i++) begin
         e = ref_exp(m, dv, q0, i);
         if ((stk ? q0 : e) != e) mism++;
      end
      e       = ref_exp(m, dv, q0, n);
      exp_err = (mism > 0);
      exp_cnt = (exp_cnt + mism > 255) ? 255 : exp_cnt + mism;
      enb_n  = 0;
      done_c = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         if (c == 1) chk("ready_low", 32'(CMD_READY), 32'd0);
         if (ENB === 1'b1) begin
            enb_n++;
            if (enb_n == 1) begin
               chk("run_modo", 32'(MODO), 32'(m));
               chk("run_d", 32'(D), 32'(dv));
            end
         end
         if (DONE === 1'b1) begin
            done_c = c;
            chk("done_err", 32'(ERR), 32'(exp_err));
            chk("done_qexp", 32'(Q_EXP), 32'(e));
            chk("done_enb", 32'(ENB), 32'd0);
            break;
         end
      end
      chk("enb_cycles", 32'(enb_n), 32'(n));
      chk("done_cycle", 32'(done_c), 32'(n + 1));
      @(negedge CLK);
      chk("ready_back", 32'(CMD_READY), 32'd1);
      chk("done_pulse", 32'(DONE), 32'd0);
      chk("err_hold", 32'(ERR), 32'(exp_err));
      chk("err_cnt", 32'(ERR_CNT), 32'(exp_cnt));
      chk("modo_hold", 32'(MODO), 32'(m));
      CMD_VALID = 1'b0;
      stuck     = 1'b0;
   endtask

   initial begin
      RESET_L   = 1'b0;
      CMD_VALID = 1'b0;
      CMD_MODO  = 2'b00;
      CMD_D     = 4'd0;
      CMD_STEPS = '0;
      repeat (3) @(negedge CLK);
      RESET_L = 1'b1;
      chk("rst_ready", 32'(CMD_READY), 32'd1);
      chk("rst_enb", 32'(ENB), 32'd0);
      chk("rst_modo", 32'(MODO), 32'd0);
      chk("rst_d", 32'(D), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_errcnt", 32'(ERR_CNT), 32'd0);
      chk("rst_qexp", 32'(Q_EXP), 32'd0);

      // Up across 15->0
      preload(4'd14);
      do_cmd(2'b00, 4'd0, 3, 1'b0);
      // Down-by-3 across 2->15
      preload(4'd2);
      do_cmd(2'b10, 4'd0, 2, 1'b0);
      // Load
      do_cmd(2'b11, 4'd9, 1, 1'b0);
      // Wrap corners
      preload(4'd0);
      do_cmd(2'b01, 4'd0, 1, 1'b0);
      preload(4'd1);
      do_cmd(2'b10, 4'd0, 1, 1'b0);
      preload(4'd15);
      do_cmd(2'b00, 4'd0, 1, 1'b0);
      // Stuck counter: four mismatches, then ERR clears on next accept
      preload(4'd5);
      do_cmd(2'b00, 4'd0, 4, 1'b1);
      do_cmd(2'b01, 4'd0, 2, 1'b0);
      // Zero steps, immediately followed by another command
      do_cmd(2'b11, 4'd3, 0, 1'b0);
      do_cmd(2'b00, 4'd0, 0, 1'b0);
      do_cmd(2'b01, 4'd0, 3, 1'b0);

      // Random commands
      for (int r = 0; r < 24; r++) begin
         if ($urandom_range(0, 2) == 0) preload(4'($urandom_range(0, 15)));
         do_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      end

      // Reset during second RUN cycle of a 5-step command
      stuck     = 1'b1;
      CMD_MODO  = 2'b00;
      CMD_D     = 4'd0;
      CMD_STEPS = STEPS_W'(5);
      CMD_VALID = 1'b1;
      chk("abort_ready", 32'(CMD_READY), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      chk("abort_err_live", 32'(ERR), 32'd1);
      RESET_L   = 1'b0;
      CMD_VALID = 1'b0;
      @(negedge CLK);
      RESET_L = 1'b1;
      stuck   = 1'b0;
      exp_cnt = 0;
      chk("abort_enb", 32'(ENB), 32'd0);
      chk("abort_done", 32'(DONE), 32'd0);
      chk("abort_err", 32'(ERR), 32'd0);
      chk("abort_errcnt", 32'(ERR_CNT), 32'd0);
      chk("abort_ready_after", 32'(CMD_READY), 32'd1);
      chk("abort_qexp", 32'(Q_EXP), 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         chk("abort_quiet", 32'({ENB, DONE}), 32'd0);
      end

      // Drive ERR_CNT into saturation
      for (int s = 0; s < 18; s++) begin
         do_cmd(2'b00, 4'd0, 15, 1'b1);
      end
      chk("sat_final", 32'(ERR_CNT), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
